// File: rtl/npg_pulse_scheduler_pkg.sv
// Shared types, widths and helpers for the stimulation pulse scheduler.
package npg_pulse_scheduler_pkg;

    localparam int unsigned ELEC_W  = 4;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned AMP_W   = 6;
    localparam int unsigned AMP_MAX = 50;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PH_A  = 3'd2,
        ST_GAP1  = 3'd3,
        ST_PH_B  = 3'd4,
        ST_GAP2  = 3'd5,
        ST_DISCH = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    typedef struct packed {
        logic [ELEC_W-1:0]  elec1;
        logic [ELEC_W-1:0]  elec2;
        logic [PHASE_W-1:0] phase;
    } pulse_cfg_t;

    // True when exactly one electrode bit is set.
    function automatic logic onehot4(input logic [ELEC_W-1:0] v);
        return (v != '0) && ((v & (v - ELEC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/npg_pulse_scheduler_rr_arbiter.sv
// Round-robin pick: first pending channel at or after rr_ptr, wrapping.
module npg_pulse_scheduler_rr_arbiter #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NCH-1:0]   pending,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NCH-1:0]   pick_c
);

    // Scan channels starting at the pointer; the first hit wins.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        pick_c = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NCH);
            if (!found && pending[idx]) begin
                pick_c[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npg_pulse_scheduler.sv
// Shares one biphasic output stage between NCH pulse channels, round-robin.
module npg_pulse_scheduler
    import npg_pulse_scheduler_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned DIS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*ELEC_W-1:0] ch_elec1,
    input  logic [NCH*ELEC_W-1:0] ch_elec2,
    input  logic [NCH*PHASE_W-1:0] ch_phase,
    input  logic [NCH*AMP_W-1:0]  ch_amp,
    output logic [ELEC_W-1:0]     up_switches,
    output logic [ELEC_W-1:0]     down_switches,
    output logic [AMP_W-1:0]      dac_amp,
    output logic [NCH-1:0]        grant,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        cfg_err,
    output logic [NCH-1:0]        overrun,
    output logic                  busy
);

    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    pulse_cfg_t        cfg_q, cfg_d;
    logic [NCH-1:0]    pending_q, pending_d;
    logic [NCH-1:0]    overrun_q, overrun_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ELEC_W-1:0] up_q, up_d, down_q, down_d;
    logic [AMP_W-1:0]  dac_q, dac_d;
    logic [NCH-1:0]    grant_q, grant_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;

    logic [NCH-1:0]    pick_c;
    pulse_cfg_t        sel_cfg_c;
    logic [AMP_W-1:0]  sel_amp_c;
    logic [PTR_W-1:0]  next_ptr_c;
    logic              cfg_ok_c;

    npg_pulse_scheduler_rr_arbiter #(.NCH(NCH), .PTR_W(PTR_W)) u_arb (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .pick_c  (pick_c)
    );

    // Mux the picked channel's configuration; amplitude saturates at the DAC limit.
    always_comb begin
        logic [AMP_W-1:0] raw_amp;
        sel_cfg_c = '0;
        raw_amp   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (pick_c[i]) begin
                sel_cfg_c.elec1 = ch_elec1[i*ELEC_W +: ELEC_W];
                sel_cfg_c.elec2 = ch_elec2[i*ELEC_W +: ELEC_W];
                sel_cfg_c.phase = ch_phase[i*PHASE_W +: PHASE_W];
                raw_amp         = ch_amp[i*AMP_W +: AMP_W];
            end
        end
        sel_amp_c = (raw_amp > AMP_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : raw_amp;
    end

    // Round-robin pointer moves to the channel after the one just served.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_q[i]) idx = PTR_W'(i);
        end
        next_ptr_c = (idx == PTR_W'(NCH - 1)) ? '0 : idx + PTR_W'(1);
    end

    assign cfg_ok_c = onehot4(cfg_q.elec1) && onehot4(cfg_q.elec2) && (cfg_q.elec1 != cfg_q.elec2);

    // Next state, next registered outputs and pending/overrun bookkeeping.
    always_comb begin
        logic [NCH-1:0] clr;
        logic [NCH-1:0] exempt;
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        dac_d     = dac_q;
        done_d    = '0;
        cfg_err_d = '0;
        up_d      = '0;
        down_d    = '0;
        clr       = '0;
        exempt    = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable && (pending_q != '0)) begin
                    state_d = ST_SETUP;
                    grant_d = pick_c;
                    dac_d   = sel_amp_c;
                    cfg_d   = sel_cfg_c;
                end
            end
            ST_SETUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!cfg_ok_c) begin
                    state_d   = ST_IDLE;
                    done_d    = grant_q;
                    cfg_err_d = grant_q;
                    clr       = grant_q;
                end else begin
                    state_d = ST_PH_A;
                    cnt_d   = '0;
                end
            end
            ST_PH_A: begin
                if (!enable) begin
                    state_d = ST_GAP2;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(cfg_q.phase)) begin
                    state_d = ST_GAP1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP1: begin
                if (!enable) begin
                    state_d = ST_GAP2;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_PH_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PH_B: begin
                if (!enable || (cnt_q == CNT_W'(cfg_q.phase))) begin
                    state_d = ST_GAP2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP2: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_DISCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DISCH: begin
                if (cnt_q == CNT_W'(DIS_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                clr      = grant_q;
                exempt   = grant_q;
                rr_ptr_d = next_ptr_c;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_PH_A: begin
                up_d   = cfg_q.elec1;
                down_d = cfg_q.elec2;
            end
            ST_PH_B: begin
                up_d   = cfg_q.elec2;
                down_d = cfg_q.elec1;
            end
            ST_DISCH: down_d = cfg_q.elec1 | cfg_q.elec2;
            default: ;
        endcase

        if (state_d == ST_IDLE) begin
            grant_d = '0;
            dac_d   = '0;
        end
        busy_d = (state_d != ST_IDLE);

        overrun_d = overrun_q | (req & pending_q & ~exempt & {NCH{enable}});
        pending_d = enable ? ((pending_q & ~clr) | req) : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cfg_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= '0;
            up_q      <= '0;
            down_q    <= '0;
            dac_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            cfg_err_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_ptr_q  <= rr_ptr_d;
            up_q      <= up_d;
            down_q    <= down_d;
            dac_q     <= dac_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            busy_q    <= busy_d;
        end
    end

    assign up_switches   = up_q;
    assign down_switches = down_q;
    assign dac_amp       = dac_q;
    assign grant         = grant_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_npg_pulse_scheduler.sv
// Directed and random checks for the pulse scheduler.
module tb_npg_pulse_scheduler;

    localparam int unsigned NCH = 4;

    logic             clk;
    logic             resetn;
    logic             enable;
    logic [NCH-1:0]   req;
    logic [NCH*4-1:0] ch_elec1;
    logic [NCH*4-1:0] ch_elec2;
    logic [NCH*3-1:0] ch_phase;
    logic [NCH*6-1:0] ch_amp;
    logic [3:0]       up_switches;
    logic [3:0]       down_switches;
    logic [5:0]       dac_amp;
    logic [NCH-1:0]   grant;
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   cfg_err;
    logic [NCH-1:0]   overrun;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    npg_pulse_scheduler #(.NCH(NCH), .GAP_CYCLES(1), .DIS_CYCLES(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .req           (req),
        .ch_elec1      (ch_elec1),
        .ch_elec2      (ch_elec2),
        .ch_phase      (ch_phase),
        .ch_amp        (ch_amp),
        .up_switches   (up_switches),
        .down_switches (down_switches),
        .dac_amp       (dac_amp),
        .grant         (grant),
        .done          (done),
        .cfg_err       (cfg_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [3:0] e1, input logic [3:0] e2,
                           input logic [2:0] p, input logic [5:0] amp);
        ch_elec1[ch*4 +: 4] = e1;
        ch_elec2[ch*4 +: 4] = e2;
        ch_phase[ch*3 +: 3] = p;
        ch_amp[ch*6 +: 6]   = amp;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_sw"}, {up_switches, down_switches}, 0);
        chk({tag, "_dac"}, 32'(dac_amp), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cfgerr"}, 32'(cfg_err), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Entered in the SETUP cycle; returns in the IDLE cycle after DONE.
    task automatic play_pulse(input int ch, input logic [3:0] e1, input logic [3:0] e2,
                              input int p, input int amp);
        logic [31:0] g;
        g = 32'(1) << ch;
        chk("setup_grant", 32'(grant), g);
        chk("setup_dac", 32'(dac_amp), 32'(amp));
        chk("setup_sw", {up_switches, down_switches}, 0);
        chk("setup_busy", 32'(busy), 1);
        for (int k = 0; k <= p; k++) begin
            tick();
            chk("pha_sw", {up_switches, down_switches}, {e1, e2});
            chk("pha_grant", 32'(grant), g);
        end
        tick();
        chk("gap1_sw", {up_switches, down_switches}, 0);
        for (int k = 0; k <= p; k++) begin
            tick();
            chk("phb_sw", {up_switches, down_switches}, {e2, e1});
        end
        tick();
        chk("gap2_sw", {up_switches, down_switches}, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("disch_sw", {up_switches, down_switches}, {4'b0000, e1 | e2});
            chk("disch_done", 32'(done), 0);
        end
        tick();
        chk("done_strobe", 32'(done), g);
        chk("done_sw", {up_switches, down_switches}, 0);
        chk("done_grant", 32'(grant), g);
        tick();
        chk("post_done", 32'(done), 0);
        chk("post_grant", 32'(grant), 0);
        chk("post_busy", 32'(busy), 0);
    endtask

    task automatic wait_done(input int ch, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < max_cycles && !seen; k++) begin
            tick();
            seen = done[ch];
        end
        chk($sformatf("wait_done_ch%0d", ch), 32'(seen), 1);
    endtask

    logic [3:0] prev_up, prev_down;

    initial begin
        resetn   = 1'b0;
        enable   = 1'b0;
        req      = '0;
        ch_elec1 = '0;
        ch_elec2 = '0;
        ch_phase = '0;
        ch_amp   = '0;
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        enable = 1'b1;
        tick();

        // Basic pulse on ch0 with request-to-grant latency.
        set_cfg(0, 4'b0100, 4'b0001, 3'd3, 6'd50);
        req = 4'b0001;
        tick();
        req = '0;
        chk("lat_n1_grant", 32'(grant), 0);
        tick();
        play_pulse(0, 4'b0100, 4'b0001, 3, 50);

        // Simultaneous ch1/ch3, then pointer wraps so ch1 beats ch2.
        set_cfg(1, 4'b1000, 4'b0010, 3'd1, 6'd10);
        set_cfg(2, 4'b0010, 4'b1000, 3'd0, 6'd33);
        set_cfg(3, 4'b0001, 4'b0100, 3'd0, 6'd5);
        req = 4'b1010;
        tick();
        req = '0;
        tick();
        play_pulse(1, 4'b1000, 4'b0010, 1, 10);
        req = 4'b0110;
        tick();
        req = '0;
        play_pulse(3, 4'b0001, 4'b0100, 0, 5);
        tick();
        play_pulse(1, 4'b1000, 4'b0010, 1, 10);
        tick();
        play_pulse(2, 4'b0010, 4'b1000, 0, 33);
        chk("arb_no_ovr", 32'(overrun), 0);

        // Illegal electrode configuration on ch2.
        set_cfg(2, 4'b0010, 4'b0010, 3'd2, 6'd20);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        chk("cfg_setup_grant", 32'(grant), 32'h4);
        chk("cfg_setup_err", 32'(cfg_err), 0);
        chk("cfg_setup_sw", {up_switches, down_switches}, 0);
        tick();
        chk("cfg_err_strobe", 32'(cfg_err), 32'h4);
        chk("cfg_done_strobe", 32'(done), 32'h4);
        chk("cfg_grant_off", 32'(grant), 0);
        chk("cfg_sw", {up_switches, down_switches}, 0);
        tick();
        chk("cfg_err_clear", 32'(cfg_err), 0);
        chk("cfg_idle", 32'(busy), 0);

        // Overrun on waiting ch0; re-request of ch1 in its DONE cycle is legal.
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b0001;
        tick();
        chk("ovr_first", 32'(overrun), 0);
        req = 4'b0001;
        tick();
        req = '0;
        chk("ovr_set", 32'(overrun), 32'h1);
        wait_done(1, 40);
        req = 4'b0010;
        tick();
        req = '0;
        chk("ovr_done_exempt", 32'(overrun), 32'h1);
        wait_done(0, 40);
        wait_done(1, 40);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        tick();

        // Enable dropped during PH_A: forced GAP2, DISCH, DONE, pending flushed.
        set_cfg(0, 4'b0100, 4'b0001, 3'd3, 6'd50);
        req = 4'b0001;
        tick();
        req = 4'b1000;
        tick();
        req = '0;
        tick();
        chk("en_pha_sw", {up_switches, down_switches}, 8'h41);
        enable = 1'b0;
        req    = 4'b0010;
        tick();
        req = '0;
        chk("en_gap2_sw", {up_switches, down_switches}, 0);
        chk("en_gap2_busy", 32'(busy), 1);
        tick();
        chk("en_disch1", {up_switches, down_switches}, 8'h05);
        tick();
        chk("en_disch2", {up_switches, down_switches}, 8'h05);
        tick();
        chk("en_done", 32'(done), 32'h1);
        tick();
        chk("en_idle_busy", 32'(busy), 0);
        tick();
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("en_flushed_busy", 32'(busy), 0);
        chk("en_flushed_grant", 32'(grant), 0);

        // Reset in the middle of PH_B.
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 6; k++) tick();
        chk("rst_phb_sw", {up_switches, down_switches}, 8'h14);
        resetn = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        resetn = 1'b1;
        tick();
        tick();
        chk("rst_after_busy", 32'(busy), 0);

        // Random traffic with safety invariants checked every cycle.
        prev_up   = '0;
        prev_down = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if ($urandom_range(0, 63) == 0) begin
                    int r1, r2;
                    r1 = int'($urandom_range(0, 3));
                    r2 = (r1 + 1 + int'($urandom_range(0, 2))) % 4;
                    if ($urandom_range(0, 15) == 0) r2 = r1;
                    set_cfg(c, 4'(1 << r1), 4'(1 << r2), 3'($urandom_range(0, 7)),
                            6'($urandom_range(0, 50)));
                end
                req[c] = ($urandom_range(0, 15) == 0);
            end
            enable = ($urandom_range(0, 99) != 0);
            resetn = ($urandom_range(0, 1999) != 0);
            tick();
            chk("inv_overlap", 32'(up_switches & down_switches), 0);
            chk("inv_flip", 32'((up_switches & prev_down) | (down_switches & prev_up)), 0);
            chk("inv_grant_onehot0", 32'($countones(grant) > 1), 0);
            chk("inv_dac_max", 32'(dac_amp > 6'd50), 0);
            prev_up   = up_switches;
            prev_down = down_switches;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
